// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants and types for the seven-segment scan driver.
//   NUM_DIGITS : number of display digits / scan slots
//   SEG_OFF    : active-low "all segments dark" pattern {g,f,e,d,c,b,a}
//   SEG_TABLE  : active-low segment patterns for hex digits 0..F
//   scan_state_t : scan FSM states (BLANK gap, DISPLAY window)
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index = digit value; bit 0 = segment a, bit 6 = segment g; 0 = lit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    typedef enum logic {
        BLANK   = 1'b0,
        DISPLAY = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational 4-bit digit to active-low seven-segment decoder.
//   i_digit : 4-bit digit value (0..F)
//   o_seg   : active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_digit];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexes an 8-digit display bus onto a common-anode seven-segment
// display. The bus is snapshotted once per frame so a frame never mixes old
// and new values; each slot starts with a blanking gap to suppress ghosting.
// BLANK_CYCLES must lie strictly between 0 and FREQ_HZ/SLOT_HZ.
//   clk          : system clock
//   reset        : synchronous active-high reset
//   digits_in    : 8 x 4-bit digits, [3:0] is the rightmost digit (slot 0)
//   digit_enable : bit k lights digit k
//   dp_enable    : bit k lights decimal point k (only when digit k is lit)
//   anode        : active-low digit select
//   cathode      : active-low segments {g,f,e,d,c,b,a}
//   dp           : active-low decimal point
//   frame_start  : one-cycle pulse marking the snapshot cycle
// -----------------------------------------------------------------------------
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int FREQ_HZ      = 100000000,
    parameter int SLOT_HZ      = 8000,
    parameter int BLANK_CYCLES = 1000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] digits_in,
    input  logic [7:0]  digit_enable,
    input  logic [7:0]  dp_enable,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        frame_start
);

    localparam int CYCLES_PER_SLOT = FREQ_HZ / SLOT_HZ;
    localparam int CNT_W           = $clog2(CYCLES_PER_SLOT);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CYCLES_PER_SLOT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_slot;
    logic [31:0]      r_snap_digits;
    logic [7:0]       r_snap_en;
    logic [7:0]       r_snap_dp;
    logic [7:0]       r_anode;
    logic [6:0]       r_cathode;
    logic             r_dp;
    logic             r_frame_start;

    logic [3:0]       w_slot_digit;
    logic [6:0]       w_slot_seg;
    logic [7:0]       w_sel;
    logic             w_frame_edge;

    // Digit select for the current slot, already gated by the snapshotted
    // enable map: at most one bit can be set since r_slot matches one index.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
            assign w_sel[gi] = (r_slot == 3'(gi)) && r_snap_en[gi];
        end
    endgenerate

    assign w_slot_digit = r_snap_digits[{r_slot, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .i_digit (w_slot_digit),
        .o_seg   (w_slot_seg)
    );

    // First cycle of slot 0's blanking gap; also the state right after reset.
    assign w_frame_edge = (r_state == BLANK) && (r_slot == 3'd0) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= BLANK;
            r_cnt         <= '0;
            r_slot        <= 3'd0;
            r_snap_digits <= '0;
            r_snap_en     <= '0;
            r_snap_dp     <= '0;
            r_anode       <= 8'hFF;
            r_cathode     <= SEG_OFF;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_edge;
            if (w_frame_edge) begin
                r_snap_digits <= digits_in;
                r_snap_en     <= digit_enable;
                r_snap_dp     <= dp_enable;
            end

            case (r_state)
                BLANK: begin
                    r_anode   <= 8'hFF;
                    r_cathode <= SEG_OFF;
                    r_dp      <= 1'b1;
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= DISPLAY;
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                DISPLAY: begin
                    // Disabled digits stay dark but still use their slot so
                    // every lit digit gets the same duty cycle.
                    r_anode   <= ~w_sel;
                    r_cathode <= (|w_sel) ? w_slot_seg : SEG_OFF;
                    r_dp      <= ~(|(w_sel & r_snap_dp));
                    if (r_cnt == SLOT_LAST) begin
                        r_state <= BLANK;
                        r_cnt   <= '0;
                        r_slot  <= r_slot + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= BLANK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign anode       = r_anode;
    assign cathode     = r_cathode;
    assign dp          = r_dp;
    assign frame_start = r_frame_start;

endmodule
